// File: rtl/bmul_pkg.sv
// Shared types and helpers for the bmul_seq iterative multiplier.
// State encoding, default width and operand magnitude helper.
package bmul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int DEF_DATAWD = 8;
   localparam int MAGWD      = 64;

   // Caller sign-extends x when sgn=1; the most negative value maps to
   // its unsigned magnitude once truncated back to the operand width.
   function automatic logic [MAGWD-1:0] mag(
      input logic [MAGWD-1:0] x,
      input logic             sgn
   );
      mag = (sgn && x[MAGWD-1]) ? -x : x;
   endfunction

endpackage

// File: rtl/bmul_seq_pp_gen.sv
// Partial product of the multiplicand magnitude and one BPC-bit chunk.
// Kept separate so a recoded (Booth) generator can replace it later.
module bmul_pp_gen #(
   parameter int DATAWD = 8,
   parameter int BPC    = 1
) (
   input  logic [DATAWD-1:0]     a,
   input  logic [BPC-1:0]        chunk,
   output logic [DATAWD+BPC-1:0] pp
);

   assign pp = {{BPC{1'b0}}, a} * {{DATAWD{1'b0}}, chunk};

endmodule

// File: rtl/bmul_seq.sv
// Iterative shift-add multiplier, BPC multiplier bits retired per cycle.
// Optional BMUL_SEQ_EARLY_TERM_EN: finish once remaining multiplier is 0.
module bmul_seq
   import bmul_pkg::*;
#(
   parameter int DATAWD = DEF_DATAWD,
   parameter int BPC    = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                iValid,
   output logic                iReady,
   input  logic                iSigned,
   input  logic [DATAWD-1:0]   iA,
   input  logic [DATAWD-1:0]   iB,
   output logic                oValid,
   input  logic                oReady,
   output logic [2*DATAWD-1:0] oC
);

   localparam int NCYC = DATAWD / BPC;
   localparam int PW   = 2 * DATAWD;
   localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(NCYC - 1);

   state_t                  state;
   logic [DATAWD-1:0]       a_mag;
   logic [DATAWD-1:0]       b_rem;
   logic [DATAWD-1:0]       b_next;
   logic                    neg;
   logic [PW-1:0]           acc;
   logic [PW-1:0]           acc_next;
   logic [PW-1:0]           pp_ext;
   logic [CW-1:0]           cnt;
   logic [DATAWD+BPC-1:0]   pp;
   logic                    last;
   logic [MAGWD-1:0]        a_ext;
   logic [MAGWD-1:0]        b_ext;

   assign iReady = (state == IDLE);

   bmul_pp_gen #(
      .DATAWD (DATAWD),
      .BPC    (BPC)
   ) u_pp (
      .a     (a_mag),
      .chunk (b_rem[BPC-1:0]),
      .pp    (pp)
   );

   // Next accumulator, remaining multiplier and end-of-operation flag.
   always_comb begin
      a_ext    = {{(MAGWD-DATAWD){iSigned & iA[DATAWD-1]}}, iA};
      b_ext    = {{(MAGWD-DATAWD){iSigned & iB[DATAWD-1]}}, iB};
      pp_ext   = PW'(pp);
      acc_next = acc + (pp_ext << (cnt * BPC));
      b_next   = b_rem >> BPC;
      last     = (cnt == CNT_LAST);
`ifdef BMUL_SEQ_EARLY_TERM_EN
      last     = last || (b_next == '0);
`endif
   end

   // Control FSM with registered result and valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         a_mag  <= '0;
         b_rem  <= '0;
         neg    <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         oC     <= '0;
         oValid <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (iValid) begin
                  a_mag <= DATAWD'(mag(a_ext, iSigned));
                  b_rem <= DATAWD'(mag(b_ext, iSigned));
                  neg   <= iSigned & (iA[DATAWD-1] ^ iB[DATAWD-1]);
                  acc   <= '0;
                  cnt   <= '0;
                  state <= CALC;
               end
            end
            CALC: begin
               acc   <= acc_next;
               b_rem <= b_next;
               cnt   <= cnt + CW'(1);
               if (last) begin
                  oC     <= neg ? -acc_next : acc_next;
                  oValid <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (oReady) begin
                  oValid <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bmul_seq.sv
// Bench for bmul_seq: 8-bit/BPC=1 and 16-bit/BPC=4 instances
// against an arithmetic reference model of product and latency.
module tb_bmul_seq;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        v8 = 1'b0, r8, s8 = 1'b0, ov8, or8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic [15:0] c8;

   logic        v16 = 1'b0, r16, s16 = 1'b0, ov16, or16 = 1'b0;
   logic [15:0] a16 = '0, b16 = '0;
   logic [31:0] c16;

   int chk = 0;
   int err = 0;

   always #5 clk = ~clk;

   bmul_seq #(.DATAWD(8), .BPC(1)) u8 (
      .clk(clk), .rst_n(rst_n), .iValid(v8), .iReady(r8),
      .iSigned(s8), .iA(a8), .iB(b8), .oValid(ov8),
      .oReady(or8), .oC(c8)
   );

   bmul_seq #(.DATAWD(16), .BPC(4)) u16 (
      .clk(clk), .rst_n(rst_n), .iValid(v16), .iReady(r16),
      .iSigned(s16), .iA(a16), .iB(b16), .oValid(ov16),
      .oReady(or16), .oC(c16)
   );

   function automatic longint sx(input logic [15:0] x, input int w,
                                 input bit s);
      longint v;
      v = longint'(x) & ((64'sd1 <<< w) - 1);
      if (s && x[w-1]) v = v - (64'sd1 <<< w);
      return v;
   endfunction

   function automatic logic [31:0] ref_mul(input logic [15:0] a,
                                           input logic [15:0] b,
                                           input bit s, input int w);
      longint p;
      p = sx(a, w, s) * sx(b, w, s);
      p = p & ((64'sd1 <<< (2 * w)) - 1);
      return p[31:0];
   endfunction

   function automatic int ref_lat(input logic [15:0] b, input bit s,
                                  input int w, input int bpc);
`ifdef BMUL_SEQ_EARLY_TERM_EN
      longint m;
      int hb;
      int n;
      m = sx(b, w, s);
      if (m < 0) m = -m;
      hb = -1;
      for (int i = 0; i < w; i++) if (m[i]) hb = i;
      n = (hb + 1 + bpc - 1) / bpc;
      return (n < 1) ? 1 : n;
`else
      return w / bpc + 0 * (b[0] + s);
`endif
   endfunction

   task automatic run_op(input bit big, input logic [15:0] a,
                         input logic [15:0] b, input bit s,
                         output logic [31:0] oc, output int lat,
                         output bit busy_ok);
      bit got;
      @(negedge clk);
      if (big) begin
         v16 = 1'b1; a16 = a; b16 = b; s16 = s;
      end else begin
         v8 = 1'b1; a8 = a[7:0]; b8 = b[7:0]; s8 = s;
      end
      @(posedge clk); #1;
      v8 = 1'b0; v16 = 1'b0;
      a8 = 'x; b8 = 'x; a16 = 'x; b16 = 'x;
      busy_ok = 1'b1;
      lat = -1;
      oc = '0;
      got = 1'b0;
      if (big ? r16 : r8) busy_ok = 1'b0;
      for (int n = 1; n <= 40 && !got; n++) begin
         @(posedge clk); #1;
         if (big ? ov16 : ov8) begin
            got = 1'b1;
            lat = n;
            oc = big ? c16 : {16'h0, c8};
         end else if (big ? r16 : r8) begin
            busy_ok = 1'b0;
         end
      end
      if (got) begin
         if (big) or16 = 1'b1; else or8 = 1'b1;
         @(posedge clk); #1;
         or8 = 1'b0; or16 = 1'b0;
      end
   endtask

   task automatic test_reset();
      chk++; if (r8 !== 1'b1) begin err++;
         $display("FAIL reset_ready8 got %b want 1", r8); end
      chk++; if (ov8 !== 1'b0) begin err++;
         $display("FAIL reset_valid8 got %b want 0", ov8); end
      chk++; if (c8 !== 16'h0) begin err++;
         $display("FAIL reset_c8 got %h want 0", c8); end
      chk++; if (r16 !== 1'b1) begin err++;
         $display("FAIL reset_ready16 got %b want 1", r16); end
      chk++; if (ov16 !== 1'b0) begin err++;
         $display("FAIL reset_valid16 got %b want 0", ov16); end
      chk++; if (c16 !== 32'h0) begin err++;
         $display("FAIL reset_c16 got %h want 0", c16); end
   endtask

   task automatic test_vectors8(input string nm, input logic [15:0] a,
                                input logic [15:0] b, input bit s,
                                input logic [31:0] want);
      logic [31:0] oc;
      int lat;
      bit busy;
      run_op(1'b0, a, b, s, oc, lat, busy);
      chk++; if (oc !== want || oc !== ref_mul(a, b, s, 8)) begin err++;
         $display("FAIL %s result got %h want %h", nm, oc, want); end
      chk++; if (lat !== ref_lat(b, s, 8, 1)) begin err++;
         $display("FAIL %s latency got %0d want %0d", nm, lat,
                  ref_lat(b, s, 8, 1)); end
      chk++; if (busy !== 1'b1) begin err++;
         $display("FAIL %s ready_during_op got 1 want 0", nm); end
   endtask

   task automatic test_unsigned();
      test_vectors8("u13x11", 16'd13, 16'd11, 1'b0, 32'd143);
      test_vectors8("uFFxFF", 16'hFF, 16'hFF, 1'b0, 32'hFE01);
   endtask

   task automatic test_signed_corners();
      test_vectors8("s80x80", 16'h80, 16'h80, 1'b1, 32'h4000);
      test_vectors8("s80x01", 16'h80, 16'h01, 1'b1, 32'hFF80);
      test_vectors8("sFFx7F", 16'hFF, 16'h7F, 1'b1, 32'hFF81);
   endtask

   task automatic test_backpressure();
      bit got;
      @(negedge clk);
      v8 = 1'b1; a8 = 8'd6; b8 = 8'd7; s8 = 1'b0;
      @(posedge clk); #1;
      a8 = 8'd9; b8 = 8'd9;
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(posedge clk); #1;
         if (ov8) got = 1'b1;
      end
      chk++; if (!got) begin err++;
         $display("FAIL bp_first_valid got timeout want oValid"); end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         chk++; if (c8 !== 16'd42 || ov8 !== 1'b1 || r8 !== 1'b0) begin
            err++;
            $display("FAIL bp_hold got c=%0d v=%b r=%b want c=42 v=1 r=0",
                     c8, ov8, r8);
         end
      end
      @(negedge clk);
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
      chk++; if (ov8 !== 1'b0 || r8 !== 1'b1) begin err++;
         $display("FAIL bp_release got v=%b r=%b want v=0 r=1", ov8, r8);
      end
      @(posedge clk); #1;
      v8 = 1'b0;
      chk++; if (r8 !== 1'b0) begin err++;
         $display("FAIL bp_reaccept got ready=%b want 0", r8); end
      got = 1'b0;
      for (int n = 0; n < 40 && !got; n++) begin
         @(posedge clk); #1;
         if (ov8) got = 1'b1;
      end
      chk++; if (!got || c8 !== 16'd81) begin err++;
         $display("FAIL bp_second got %0d want 81", c8); end
      or8 = 1'b1;
      @(posedge clk); #1;
      or8 = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [31:0] oc;
      int lat;
      bit busy;
      run_op(1'b0, 16'd5, 16'd5, 1'b0, oc, lat, busy);
      @(negedge clk);
      v8 = 1'b1; a8 = 8'd200; b8 = 8'd200; s8 = 1'b0;
      @(posedge clk); #1;
      v8 = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk++; if (ov8 !== 1'b0 || c8 !== 16'h0) begin err++;
         $display("FAIL rst_mid got v=%b c=%h want v=0 c=0", ov8, c8); end
      chk++; if (r8 !== 1'b1) begin err++;
         $display("FAIL rst_mid_ready got %b want 1", r8); end
      @(negedge clk);
      rst_n = 1'b1;
      test_vectors8("rst_3x5", 16'd3, 16'd5, 1'b0, 32'd15);
   endtask

   task automatic test_random();
      logic [31:0] oc;
      logic [15:0] a, b;
      bit s, busy;
      int lat;
      for (int i = 0; i < 1000; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         if (i % 50 == 0) a = 16'h8000;
         if (i % 70 == 1) b = 16'h8000;
         s = 1'($urandom_range(0, 1));
         run_op(1'b1, a, b, s, oc, lat, busy);
         chk++; if (oc !== ref_mul(a, b, s, 16)) begin err++;
            $display("FAIL rnd16 %h*%h s=%b got %h want %h", a, b, s, oc,
                     ref_mul(a, b, s, 16)); end
         chk++; if (lat !== ref_lat(b, s, 16, 4)) begin err++;
            $display("FAIL rnd16_lat got %0d want %0d", lat,
                     ref_lat(b, s, 16, 4)); end
      end
      for (int i = 0; i < 200; i++) begin
         a = 16'($urandom_range(0, 255));
         b = 16'($urandom_range(0, 255));
         s = 1'($urandom_range(0, 1));
         run_op(1'b0, a, b, s, oc, lat, busy);
         chk++; if (oc !== ref_mul(a, b, s, 8)) begin err++;
            $display("FAIL rnd8 %h*%h s=%b got %h want %h", a, b, s, oc,
                     ref_mul(a, b, s, 8)); end
         chk++; if (lat !== ref_lat(b, s, 8, 1)) begin err++;
            $display("FAIL rnd8_lat got %0d want %0d", lat,
                     ref_lat(b, s, 8, 1)); end
      end
   endtask

   task automatic test_early_term();
      test_vectors8("et_b0", 16'h5A, 16'h00, 1'b0, 32'h0);
      test_vectors8("et_b3", 16'h21, 16'h03, 1'b0, 32'h63);
      test_vectors8("et_bm1", 16'h05, 16'hFF, 1'b1, 32'hFFFB);
   endtask

   initial begin
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      test_unsigned();
      test_signed_corners();
      test_backpressure();
      test_reset_mid();
      test_early_term();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", chk, err);
      $finish;
   end

endmodule
